// File: rtl/mips_pkg.sv
// Types and constants shared by the instruction-memory side of the mips top level.
package mips_pkg;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 64;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Packs an accepted byte stream into little-endian 32-bit words; word_valid_o
// pulses for one cycle after the fourth byte and word_o holds between words.
module byte_packer (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        last_o
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    word_d  = word_q;
    valid_d = 1'b0;
    last_o  = accept_i && (lane_q == 2'd3);
    if (clear_i) begin
      lane_d  = 2'd0;
      shift_d = '0;
    end else if (accept_i) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_i, shift_q[23:8]};
      if (last_o) begin
        word_d  = {byte_i, shift_q};
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      lane_q  <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader for imem: receives a framed, checksummed byte stream, writes the
// words to sequential imem addresses and holds the CPU in reset until verified.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_reset_o,
  output logic              done_o,
  output logic              error_o
);

  loader_state_t     state_q, state_d;
  logic [7:0]        n_q, n_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic [7:0]        acc_q, acc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic        accept;
  logic        pk_clear;
  logic        pk_last;
  logic        pk_valid;
  logic [31:0] pk_word;

  assign accept = byte_valid_i && ready_q;

  byte_packer u_packer (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .clear_i      (pk_clear),
    .accept_i     (accept && (state_q == DATA)),
    .byte_i       (byte_data_i),
    .word_o       (pk_word),
    .word_valid_o (pk_valid),
    .last_o       (pk_last)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    acc_d    = acc_q;
    addr_d   = addr_q;
    pk_clear = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d  = HDR;
          wcnt_d   = '0;
          acc_d    = 8'h00;
          pk_clear = 1'b1;
        end
      end
      HDR: begin
        if (accept) begin
          n_d = byte_data_i;
          if (byte_data_i == 8'h00)               state_d = CSUM;
          else if (32'(byte_data_i) > DEPTH)      state_d = ERR;
          else                                    state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          acc_d = acc_q ^ byte_data_i;
          // Address is captured with the 4th byte so it is valid alongside the strobe.
          if (pk_last) begin
            addr_d = wcnt_q[ADDR_W-1:0];
            wcnt_d = wcnt_q + 1'b1;
            if (32'(wcnt_q) + 32'd1 == 32'(n_q)) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) state_d = (byte_data_i == acc_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
    ready_d     = (state_d == HDR) || (state_d == DATA) || (state_d == CSUM);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERR);
    cpu_reset_d = (state_d != DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      n_q         <= 8'h00;
      wcnt_q      <= '0;
      acc_q       <= 8'h00;
      addr_q      <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wcnt_q      <= wcnt_d;
      acc_q       <= acc_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign imem_we_o    = pk_valid;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = pk_word;
  assign done_o       = done_q;
  assign error_o      = error_q;
  assign cpu_reset_o  = cpu_reset_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frames, checksum errors,
// oversize headers, ignored restarts, mid-load reset and empty frames.
module tb_imem_loader;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o;
  logic        imem_we_o;
  logic [5:0]  imem_addr_o;
  logic [31:0] imem_wdata_o;
  logic        cpu_reset_o;
  logic        done_o;
  logic        error_o;

  imem_loader dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .start_i      (start_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_wdata_o (imem_wdata_o),
    .cpu_reset_o  (cpu_reset_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int xfer_cyc = 0;
  int widx = 0;
  logic [7:0] csum = 8'h00;

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int          exp_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (imem_we_o === 1'b1) begin
      wr_addr.push_back(int'(imem_addr_o));
      wr_data.push_back(imem_wdata_o);
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (byte_ready_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 40) chk("ready_timeout", 32'(byte_ready_o), 32'd1);
    xfer_cyc = cyc;
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk_i);
      send_byte(w[8*i +: 8]);
      csum ^= w[8*i +: 8];
    end
    exp_addr.push_back(widx);
    exp_data.push_back(w);
    exp_cyc.push_back(xfer_cyc + 1);
    widx++;
  endtask

  task automatic start_pulse();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic begin_frame(input logic [7:0] n);
    csum = 8'h00;
    widx = 0;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    wr_addr.delete();  wr_data.delete();  wr_cyc.delete();
    start_pulse();
    send_byte(n);
  endtask

  task automatic check_writes(input string tag);
    @(negedge clk_i);
    chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(exp_addr[i]));
      chk($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
      chk($sformatf("%s_lat%0d", tag, i), 32'(wr_cyc[i]), 32'(exp_cyc[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready_o), 32'd0);
    chk({tag, "_we"},    32'(imem_we_o),    32'd0);
    chk({tag, "_addr"},  32'(imem_addr_o),  32'd0);
    chk({tag, "_wdata"}, imem_wdata_o,      32'd0);
    chk({tag, "_done"},  32'(done_o),       32'd0);
    chk({tag, "_err"},   32'(error_o),      32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_reset_o), 32'd1);
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk_i);
    check_reset_outputs("rst");
    reset_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 32'(byte_ready_o), 32'd0);

    // 1: two-word frame
    begin_frame(8'd2);
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    chk("t1_csum_model", 32'(csum), 32'h2A);
    send_byte(csum);
    chk("t1_done", 32'(done_o), 32'd1);
    chk("t1_cpurst", 32'(cpu_reset_o), 32'd0);
    chk("t1_ready", 32'(byte_ready_o), 32'd0);
    check_writes("t1");

    // 2: bad checksum
    begin_frame(8'd1);
    send_word(32'h04030201, 1'b0);
    send_byte(8'h05);
    chk("t2_err", 32'(error_o), 32'd1);
    chk("t2_cpurst", 32'(cpu_reset_o), 32'd1);
    chk("t2_done", 32'(done_o), 32'd0);
    check_writes("t2");

    // 3: oversize header, then recovery
    begin_frame(8'd65);
    chk("t3_err", 32'(error_o), 32'd1);
    chk("t3_ready", 32'(byte_ready_o), 32'd0);
    check_writes("t3");
    start_pulse();
    chk("t3_err_clear", 32'(error_o), 32'd0);
    csum = 8'h00; widx = 0;
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
    wr_addr.delete();  wr_data.delete();  wr_cyc.delete();
    send_byte(8'd1);
    send_word(32'hCAFEF00D, 1'b0);
    send_byte(csum);
    chk("t3_done", 32'(done_o), 32'd1);
    check_writes("t3b");

    // 4: gaps and an ignored start mid-DATA
    begin_frame(8'd3);
    send_word(32'hA5A55A5A, 1'b1);
    start_i = 1'b1;
    send_word(32'h0BADC0DE, 1'b1);
    start_i = 1'b0;
    send_word(32'h80000001, 1'b1);
    send_byte(csum);
    chk("t4_done", 32'(done_o), 32'd1);
    check_writes("t4");

    // 5: reset after 6 payload bytes of an N=4 load
    begin_frame(8'd4);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    check_reset_outputs("t5_rst");
    byte_valid_i = 1'b1;
    @(negedge clk_i);
    chk("t5_idle_ready", 32'(byte_ready_o), 32'd0);
    byte_valid_i = 1'b0;
    begin_frame(8'd4);
    send_word(32'h00000000, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0);
    send_word(32'h13579BDF, 1'b0);
    send_word(32'h2468ACE0, 1'b0);
    send_byte(csum);
    chk("t5_done", 32'(done_o), 32'd1);
    check_writes("t5");

    // 6: empty frame, then restart from DONE
    begin_frame(8'd0);
    send_byte(8'h00);
    chk("t6_done", 32'(done_o), 32'd1);
    chk("t6_cpurst", 32'(cpu_reset_o), 32'd0);
    check_writes("t6");
    start_pulse();
    chk("t6_done_clear", 32'(done_o), 32'd0);
    chk("t6_cpurst_set", 32'(cpu_reset_o), 32'd1);
    chk("t6_hdr_ready", 32'(byte_ready_o), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
